// File: rtl/xpb_reduce_seq.sv
// xpb_reduce_seq
// Sequential reduction of a segmented upper word through a set of external
// precomputed tables. Each SEG_BITS-wide segment of the latched upper word is
// used as an index into its own table (one lookup per cycle). The returned
// values are summed into a wide unsigned accumulator, and the total is handed
// out on a valid/ready interface.
//
// The lookup address registers are loaded one cycle ahead of the segment
// counter. This makes the address for segment cnt visible during the ISSUE
// cycle that holds cnt. The table answers one cycle later. The issue flag is
// that ISSUE cycle delayed by one register, so it is high exactly when
// lut_data carries a value that belongs to this operation.
module xpb_reduce_seq #(
    parameter int SEG_BITS = 5,
    parameter int NUM_SEGS = 16,
    parameter int WIDTH    = 1024,
    localparam int SEL_W   = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1,
    localparam int ACC_W   = WIDTH + $clog2(NUM_SEGS),
    localparam int UPPER_W = NUM_SEGS * SEG_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [UPPER_W-1:0]  upper_in,
    output logic [SEL_W-1:0]    lut_seg_sel,
    output logic [SEG_BITS-1:0] lut_idx,
    input  logic [WIDTH-1:0]    lut_data,
    output logic [ACC_W-1:0]    sum_out,
    output logic                sum_valid,
    input  logic                sum_ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [SEL_W-1:0] LAST_CNT = SEL_W'(NUM_SEGS - 1);

    state_t              state_r;
    logic [SEL_W-1:0]    cnt_r;
    logic                issue_r;
    logic [ACC_W-1:0]    acc_r;
    logic [UPPER_W-1:0]  word_r;
    logic [SEL_W-1:0]    lut_seg_sel_r;
    logic [SEG_BITS-1:0] lut_idx_r;
    logic                start_ready_r;
    logic                sum_valid_r;

    logic [SEL_W-1:0]    cnt_inc_s;
    logic                accept_s;
    logic                handshake_s;

    // Extract segment k of a latched upper word.
    function automatic logic [SEG_BITS-1:0] seg_at(
        input logic [UPPER_W-1:0] word,
        input logic [SEL_W-1:0]   k
    );
        seg_at = word[k*SEG_BITS +: SEG_BITS];
    endfunction

    assign cnt_inc_s   = cnt_r + SEL_W'(1);
    assign accept_s    = start_valid && start_ready_r;
    assign handshake_s = sum_valid_r && sum_ready;

    // Control FSM, lookup address registers, issue flag, and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            issue_r       <= 1'b0;
            acc_r         <= '0;
            word_r        <= '0;
            lut_seg_sel_r <= '0;
            lut_idx_r     <= '0;
            start_ready_r <= 1'b1;
            sum_valid_r   <= 1'b0;
        end else begin
            // Data returned for the previous ISSUE cycle is folded in here.
            if (issue_r) begin
                acc_r <= acc_r + ACC_W'(lut_data);
            end

            case (state_r)
                ST_IDLE: begin
                    issue_r       <= 1'b0;
                    lut_seg_sel_r <= '0;
                    lut_idx_r     <= '0;
                    sum_valid_r   <= 1'b0;
                    if (accept_s) begin
                        word_r        <= upper_in;
                        acc_r         <= '0;
                        cnt_r         <= '0;
                        // Segment 0's address is presented on the first ISSUE cycle.
                        lut_seg_sel_r <= '0;
                        lut_idx_r     <= upper_in[SEG_BITS-1:0];
                        start_ready_r <= 1'b0;
                        state_r       <= ST_ISSUE;
                    end else begin
                        start_ready_r <= 1'b1;
                        state_r       <= ST_IDLE;
                    end
                end

                ST_ISSUE: begin
                    issue_r       <= 1'b1;
                    start_ready_r <= 1'b0;
                    sum_valid_r   <= 1'b0;
                    if (cnt_r == LAST_CNT) begin
                        cnt_r         <= '0;
                        lut_seg_sel_r <= '0;
                        lut_idx_r     <= '0;
                        state_r       <= ST_DRAIN;
                    end else begin
                        cnt_r         <= cnt_inc_s;
                        lut_seg_sel_r <= cnt_inc_s;
                        lut_idx_r     <= seg_at(word_r, cnt_inc_s);
                        state_r       <= ST_ISSUE;
                    end
                end

                ST_DRAIN: begin
                    // The last lookup value is added this cycle via issue_r.
                    issue_r       <= 1'b0;
                    lut_seg_sel_r <= '0;
                    lut_idx_r     <= '0;
                    start_ready_r <= 1'b0;
                    sum_valid_r   <= 1'b1;
                    state_r       <= ST_DONE;
                end

                ST_DONE: begin
                    issue_r       <= 1'b0;
                    lut_seg_sel_r <= '0;
                    lut_idx_r     <= '0;
                    if (handshake_s) begin
                        sum_valid_r   <= 1'b0;
                        start_ready_r <= 1'b1;
                        state_r       <= ST_IDLE;
                    end else begin
                        sum_valid_r   <= 1'b1;
                        start_ready_r <= 1'b0;
                        state_r       <= ST_DONE;
                    end
                end

                default: begin
                    state_r       <= ST_IDLE;
                    cnt_r         <= '0;
                    issue_r       <= 1'b0;
                    lut_seg_sel_r <= '0;
                    lut_idx_r     <= '0;
                    start_ready_r <= 1'b1;
                    sum_valid_r   <= 1'b0;
                end
            endcase
        end
    end

    assign start_ready = start_ready_r;
    assign sum_valid   = sum_valid_r;
    assign sum_out     = acc_r;
    assign lut_seg_sel = lut_seg_sel_r;
    assign lut_idx     = lut_idx_r;

endmodule

// File: tb/tb_xpb_reduce_seq.sv
// Self-checking bench for xpb_reduce_seq at default parameters.
// A registered bench table answers the lookups. Expected sums are computed
// directly as the sum over all segments of table(seg, segment value).
module tb_xpb_reduce_seq;

    localparam int SEG_BITS = 5;
    localparam int NUM_SEGS = 16;
    localparam int WIDTH    = 1024;
    localparam int SEL_W    = 4;
    localparam int ACC_W    = 1028;
    localparam int UPPER_W  = 80;
    localparam int NVEC     = 10;

    logic                clk;
    logic                rst_n;
    logic                start_valid;
    logic                start_ready;
    logic [UPPER_W-1:0]  upper_in;
    logic [SEL_W-1:0]    lut_seg_sel;
    logic [SEG_BITS-1:0] lut_idx;
    logic [WIDTH-1:0]    lut_data;
    logic [ACC_W-1:0]    sum_out;
    logic                sum_valid;
    logic                sum_ready;

    int checks = 0;
    int errors = 0;
    int lut_mode = 0;

    typedef struct {
        logic [UPPER_W-1:0] upper;
        int                 mode;
        logic [ACC_W-1:0]   exp_sum;
        int                 hold;
    } vec_t;

    vec_t vecs [NVEC];

    xpb_reduce_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .upper_in    (upper_in),
        .lut_seg_sel (lut_seg_sel),
        .lut_idx     (lut_idx),
        .lut_data    (lut_data),
        .sum_out     (sum_out),
        .sum_valid   (sum_valid),
        .sum_ready   (sum_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table contents: mode 0 = (seg+1)*idx, mode 1 = all ones, otherwise a hash pattern.
    function automatic logic [WIDTH-1:0] lut_fn(input int mode, input int seg, input int idx);
        logic [WIDTH-1:0] v;
        v = '0;
        case (mode)
            0: v = WIDTH'((seg + 1) * idx);
            1: v = '1;
            default: begin
                for (int w = 0; w < 32; w++) begin
                    v[w*32 +: 32] = 32'(seg * 131 + idx * 7 + w + 1) * 32'h9E3779B1;
                end
            end
        endcase
        return v;
    endfunction

    // Expected reduction: sum over every segment of its table value.
    function automatic logic [ACC_W-1:0] ref_sum(input int mode, input logic [UPPER_W-1:0] u);
        logic [ACC_W-1:0] acc;
        acc = '0;
        for (int k = 0; k < NUM_SEGS; k++) begin
            acc = acc + {4'b0000, lut_fn(mode, k, int'(u[k*SEG_BITS +: SEG_BITS]))};
        end
        return acc;
    endfunction

    // Bench table with one cycle of read latency.
    always @(posedge clk) begin
        lut_data <= lut_fn(lut_mode, int'(lut_seg_sel), int'(lut_idx));
    end

    task automatic chk(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h..%h required=%h..%h", name,
                     act[ACC_W-1:ACC_W-64], act[63:0], exp[ACC_W-1:ACC_W-64], exp[63:0]);
        end
    endtask

    function automatic logic [UPPER_W-1:0] rand_upper();
        return {16'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    // One full operation: accept, check lookup addresses and latency, hold in DONE, handshake.
    task automatic run_op(input logic [UPPER_W-1:0] u, input int mode,
                          input logic [ACC_W-1:0] exp, input int hold, input string tag);
        int n;
        lut_mode = mode;
        @(negedge clk);
        upper_in    = u;
        start_valid = 1'b1;
        chk({tag, "_start_ready_idle"}, ACC_W'(start_ready), ACC_W'(1));
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        upper_in    = rand_upper();
        chk({tag, "_start_ready_busy"}, ACC_W'(start_ready), ACC_W'(0));
        n = 0;
        while (sum_valid !== 1'b1 && n < 60) begin
            if (n < NUM_SEGS) begin
                chk({tag, "_lut_idx"}, ACC_W'(lut_idx), ACC_W'(u[n*SEG_BITS +: SEG_BITS]));
                chk({tag, "_lut_seg_sel"}, ACC_W'(lut_seg_sel), ACC_W'(n));
            end
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, ACC_W'(n), ACC_W'(17));
        for (int h = 0; h < hold; h++) begin
            chk({tag, "_hold_valid"}, ACC_W'(sum_valid), ACC_W'(1));
            chk({tag, "_hold_sum"}, sum_out, exp);
            chk({tag, "_hold_start_ready"}, ACC_W'(start_ready), ACC_W'(0));
            @(posedge clk);
            @(negedge clk);
        end
        chk({tag, "_sum_valid"}, ACC_W'(sum_valid), ACC_W'(1));
        chk({tag, "_sum_out"}, sum_out, exp);
        sum_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sum_ready = 1'b0;
        chk({tag, "_post_valid"}, ACC_W'(sum_valid), ACC_W'(0));
        chk({tag, "_post_start_ready"}, ACC_W'(start_ready), ACC_W'(1));
        chk({tag, "_idle_addr"}, ACC_W'({lut_seg_sel, lut_idx}), ACC_W'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [UPPER_W-1:0] u1;
        logic [UPPER_W-1:0] u2;
        logic [UPPER_W-1:0] ones;
        logic [ACC_W-1:0]   e1;
        logic [ACC_W-1:0]   e2;
        int                 n;
        int                 seen;

        rst_n       = 1'b0;
        start_valid = 1'b0;
        sum_ready   = 1'b0;
        upper_in    = '0;
        ones        = '1;

        // Directed vectors followed by random ones, expected sums from the model.
        vecs[0] = '{upper: '0, mode: 0, exp_sum: '0, hold: 0};
        vecs[1] = '{upper: 80'h1, mode: 0, exp_sum: 1028'd1, hold: 0};
        vecs[2] = '{upper: ones, mode: 1, exp_sum: {{1024{1'b1}}, 4'b0000}, hold: 5};
        vecs[3] = '{upper: 80'h0000_0000_0000_0000_03E0, mode: 0, exp_sum: 1028'd62, hold: 1};
        for (int i = 4; i < NVEC; i++) begin
            vecs[i].upper = rand_upper();
            if (i == 5) begin
                vecs[i].upper = vecs[i].upper & 80'hFFFF_0000_03FF_FFE0_001F;
            end
            vecs[i].mode    = 2;
            vecs[i].exp_sum = ref_sum(2, vecs[i].upper);
            vecs[i].hold    = int'($urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        chk("reset_start_ready", ACC_W'(start_ready), ACC_W'(1));
        chk("reset_sum_valid", ACC_W'(sum_valid), ACC_W'(0));
        chk("reset_sum_out", sum_out, '0);
        chk("reset_lut_seg_sel", ACC_W'(lut_seg_sel), ACC_W'(0));
        chk("reset_lut_idx", ACC_W'(lut_idx), ACC_W'(0));
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].upper, vecs[i].mode, vecs[i].exp_sum, vecs[i].hold, $sformatf("vec%0d", i));
        end

        // Reset pulsed in ISSUE with cnt = 7 aborts the operation.
        lut_mode = 2;
        @(negedge clk);
        upper_in    = rand_upper();
        start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("abort_seg_sel_at_7", ACC_W'(lut_seg_sel), ACC_W'(7));
        rst_n = 1'b0;
        #1;
        chk("abort_start_ready", ACC_W'(start_ready), ACC_W'(1));
        chk("abort_sum_valid", ACC_W'(sum_valid), ACC_W'(0));
        chk("abort_sum_out", sum_out, '0);
        chk("abort_lut_seg_sel", ACC_W'(lut_seg_sel), ACC_W'(0));
        chk("abort_lut_idx", ACC_W'(lut_idx), ACC_W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (sum_valid !== 1'b0) seen = 1;
        end
        chk("abort_no_sum_valid", ACC_W'(seen), ACC_W'(0));
        u1 = rand_upper();
        run_op(u1, 2, ref_sum(2, u1), 0, "after_abort");

        // Back-to-back: start_valid and sum_ready held high throughout.
        lut_mode = 2;
        u1 = rand_upper();
        u2 = rand_upper();
        e1 = ref_sum(2, u1);
        e2 = ref_sum(2, u2);
        @(negedge clk);
        start_valid = 1'b1;
        sum_ready   = 1'b1;
        upper_in    = u1;
        @(posedge clk);
        @(negedge clk);
        upper_in = u2;
        n = 0;
        while (sum_valid !== 1'b1 && n < 60) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("b2b_latency1", ACC_W'(n), ACC_W'(17));
        chk("b2b_sum1", sum_out, e1);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_idle_start_ready", ACC_W'(start_ready), ACC_W'(1));
        chk("b2b_idle_sum_valid", ACC_W'(sum_valid), ACC_W'(0));
        @(posedge clk);
        @(negedge clk);
        chk("b2b_second_accept", ACC_W'(start_ready), ACC_W'(0));
        start_valid = 1'b0;
        n = 0;
        while (sum_valid !== 1'b1 && n < 60) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("b2b_latency2", ACC_W'(n), ACC_W'(17));
        chk("b2b_sum2", sum_out, e2);
        @(posedge clk);
        @(negedge clk);
        sum_ready = 1'b0;
        chk("b2b_final_valid", ACC_W'(sum_valid), ACC_W'(0));
        chk("b2b_final_start_ready", ACC_W'(start_ready), ACC_W'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xpb_reduce_seq.md
XPB_REDUCE_SEQ -- requirements
Module: xpb_reduce_seq

Interface
REQ-001 Parameter SEG_BITS, default 5, width of one upper-word segment and of the lookup index.
REQ-002 Parameter NUM_SEGS, default 16, number of segments reduced per operation.
REQ-003 Parameter WIDTH, default 1024, width of one lookup value.
REQ-004 Derived ACC_W = WIDTH + clog2(NUM_SEGS), default 1028, accumulator and sum width.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start_valid  input  1  upper_in is valid.
REQ-008 start_ready  output  1  block accepts a new operation.
REQ-009 upper_in  input  NUM_SEGS*SEG_BITS  upper word; segment k is bits [k*SEG_BITS +: SEG_BITS].
REQ-010 lut_seg_sel  output  clog2(NUM_SEGS)  selects which segment's precomputed table is read.
REQ-011 lut_idx  output  SEG_BITS  5-bit index into the selected table.
REQ-012 lut_data  input  WIDTH  table output, registered one cycle after lut_seg_sel/lut_idx.
REQ-013 sum_out  output  ACC_W  sum of all NUM_SEGS looked-up values.
REQ-014 sum_valid  output  1  sum_out is valid.
REQ-015 sum_ready  input  1  consumer accepts sum_out.

Function
REQ-016 FSM states IDLE, ISSUE, DRAIN, DONE; start_ready = 1 only in IDLE.
REQ-017 IDLE: on start_valid && start_ready, latch upper_in, clear accumulator, clear segment counter cnt, go to ISSUE.
REQ-018 ISSUE: each cycle drive lut_seg_sel = cnt, lut_idx = segment cnt of latched word; increment cnt; after issuing cnt = NUM_SEGS-1, go to DRAIN.
REQ-019 A one-bit issue pipeline flag is registered high for each ISSUE cycle; when the flag is high, accumulator <= accumulator + zero-extended lut_data.
REQ-020 DRAIN lasts exactly one cycle, during which the last lookup value is added; then go to DONE.
REQ-021 DONE: sum_valid = 1, sum_out = accumulator, both held stable until sum_valid && sum_ready; then go to IDLE.
REQ-022 Latency: with accept on edge 0, lookups are issued in cycles after edges 1..NUM_SEGS, and sum_valid is high after edge NUM_SEGS+1 (17 edges at defaults).
REQ-023 Every segment is issued, including zero-valued segments; no skipping.
REQ-024 Addition is unsigned, width ACC_W, no modular reduction; NUM_SEGS*(2^WIDTH-1) fits without overflow.
REQ-025 In IDLE, lut_seg_sel and lut_idx are driven 0.
REQ-026 start_valid outside IDLE is ignored; upper_in changes after accept do not affect the operation.
REQ-027 sum_ready while not in DONE is ignored.
REQ-028 A completion and a new start cannot coincide; the earliest next accept is the cycle after the sum handshake.

Reset
REQ-029 rst_n low asynchronously forces IDLE, cnt = 0, issue flag = 0, accumulator = 0, latched word = 0.
REQ-030 Reset values: start_ready = 1, sum_valid = 0, sum_out = 0, lut_seg_sel = 0, lut_idx = 0.
REQ-031 Reset asserted mid-operation (ISSUE, DRAIN or DONE) aborts it; no sum_valid is produced for the aborted operation.

Verification
REQ-032 upper_in = 0, bench LUT returns 0 for index 0 -> sum_out = 0, sum_valid high exactly 17 edges after accept.
REQ-033 Segment 0 = 5'h01, others 0, bench LUT(seg,idx) = (seg+1)*idx -> sum_out = 1; lut_idx sequence observed as 1,0,0,...,0.
REQ-034 All segments 5'h1F, bench LUT returns 2^1024-1 for every index -> sum_out = 16*(2^1024-1) = 1028'hF_FFF...FF0.
REQ-035 sum_ready held low for 5 cycles in DONE -> sum_valid and sum_out stable, start_ready low; release -> IDLE next cycle.
REQ-036 rst_n pulsed low in ISSUE with cnt = 7 -> all outputs at reset values immediately; a following operation yields the correct sum.
REQ-037 Back-to-back operations with start_valid held high and sum_ready high -> second accept on the cycle after the first sum handshake, both sums correct.
